// File: rtl/linear_job_sched.sv
// linear_job_sched: walks the shared systolic linear engine through a batch of
// projection jobs (Q, K, V, output by default). One batch command is accepted
// in IDLE; each selected job is issued in ascending index order with its own
// weight/result base, and a per-job cycle budget aborts a hung engine.
module linear_job_sched #(
    parameter int                NUM_JOBS    = 4,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] W_STRIDE    = 32'd4096,
    parameter logic [ADDR_W-1:0] Y_STRIDE    = 32'd1024,
    parameter int                TIMEOUT_CYC = 1024,
    localparam int               JOB_W       = (NUM_JOBS > 1) ? $clog2(NUM_JOBS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [NUM_JOBS-1:0] cmd_job_mask,
    input  logic [ADDR_W-1:0]   cmd_x_base,
    input  logic [ADDR_W-1:0]   cmd_w_base,
    input  logic [ADDR_W-1:0]   cmd_y_base,
    output logic                lin_start,
    input  logic                lin_done,
    output logic [ADDR_W-1:0]   lin_x_base,
    output logic [ADDR_W-1:0]   lin_w_base,
    output logic [ADDR_W-1:0]   lin_y_base,
    output logic [JOB_W-1:0]    job_id,
    output logic                busy,
    output logic                all_done,
    output logic                err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN,
        FINISH
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [NUM_JOBS-1:0] pending_q;
    logic [ADDR_W-1:0]   x_q;
    logic [ADDR_W-1:0]   w_q;
    logic [ADDR_W-1:0]   y_q;
    // Counts cycles since the job was loaded; reads 0 in ISSUE, 1 in the first RUN cycle.
    logic [CNT_W-1:0]    tmo_cnt_q;

    logic                load_job;
    logic                set_done;
    logic                set_err;
    logic                tmo_hit;
    logic [NUM_JOBS-1:0] pend_src;
    logic [ADDR_W-1:0]   x_src;
    logic [ADDR_W-1:0]   w_src;
    logic [ADDR_W-1:0]   y_src;
    logic [JOB_W-1:0]    next_idx;

    // Lowest set bit of a job mask; 0 when the mask is empty.
    function automatic logic [JOB_W-1:0] lowest_idx(input logic [NUM_JOBS-1:0] mask);
        lowest_idx = '0;
        for (int i = NUM_JOBS - 1; i >= 0; i--) begin
            if (mask[i]) lowest_idx = JOB_W'(i);
        end
    endfunction

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

    // In IDLE the job is loaded in the same edge as the handshake, so the
    // command fields are used directly instead of their latched copies.
    assign pend_src = (state_q == IDLE) ? cmd_job_mask : pending_q;
    assign x_src    = (state_q == IDLE) ? cmd_x_base   : x_q;
    assign w_src    = (state_q == IDLE) ? cmd_w_base   : w_q;
    assign y_src    = (state_q == IDLE) ? cmd_y_base   : y_q;
    assign next_idx = lowest_idx(pend_src);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode plus the one-cycle events that drive registered outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        load_job = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (|cmd_job_mask) begin
                        state_d  = ISSUE;
                        load_job = 1'b1;
                    end else begin
                        state_d  = FINISH;
                        set_done = 1'b1;
                    end
                end
            end
            ISSUE: state_d = RUN;
            RUN: begin
                // lin_done takes priority over a coincident terminal count.
                if (lin_done) begin
                    if (|pending_q) begin
                        state_d  = ISSUE;
                        load_job = 1'b1;
                    end else begin
                        state_d  = FINISH;
                        set_done = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    set_err = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, job loading, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            x_q         <= '0;
            w_q         <= '0;
            y_q         <= '0;
            tmo_cnt_q   <= '0;
            job_id      <= '0;
            lin_x_base  <= '0;
            lin_w_base  <= '0;
            lin_y_base  <= '0;
            lin_start   <= 1'b0;
            all_done    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            lin_start   <= load_job;
            all_done    <= set_done;
            err_timeout <= set_err;

            if (state_q == IDLE && cmd_valid) begin
                pending_q <= cmd_job_mask;
                x_q       <= cmd_x_base;
                w_q       <= cmd_w_base;
                y_q       <= cmd_y_base;
            end

            if (load_job) begin
                job_id     <= next_idx;
                lin_x_base <= x_src;
                lin_w_base <= w_src + ADDR_W'(next_idx) * W_STRIDE;
                lin_y_base <= y_src + ADDR_W'(next_idx) * Y_STRIDE;
                pending_q  <= pend_src & ~(NUM_JOBS'(1) << next_idx);
                tmo_cnt_q  <= '0;
            end else if (state_q == ISSUE || state_q == RUN) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end

            if (set_err) pending_q <= '0;
        end
    end

endmodule

// File: tb/tb_linear_job_sched.sv
// Directed bench for linear_job_sched: expected job issues are queued when a
// command is driven and popped on each lin_start. Two instances share inputs:
// one with the default timeout, one with TIMEOUT_CYC=16 for timeout cases.
module tb_linear_job_sched;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [3:0]  cmd_job_mask;
    logic [31:0] cmd_x_base;
    logic [31:0] cmd_w_base;
    logic [31:0] cmd_y_base;
    logic        lin_done;
    logic        sel;

    logic        a_ready, a_start, a_busy, a_done, a_err;
    logic [31:0] a_x, a_w, a_y;
    logic [1:0]  a_job;
    logic        b_ready, b_start, b_busy, b_done, b_err;
    logic [31:0] b_x, b_w, b_y;
    logic [1:0]  b_job;

    logic        o_ready, o_start, o_busy, o_done, o_err;
    logic [31:0] o_x, o_w, o_y;
    logic [1:0]  o_job;

    typedef struct {
        logic [1:0]  job;
        logic [31:0] x;
        logic [31:0] w;
        logic [31:0] y;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_start  = 0;
    int   n_alldone = 0;
    int   n_err    = 0;
    int   n_b2b    = 0;
    logic prev_start = 1'b0;

    linear_job_sched dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
        .cmd_job_mask(cmd_job_mask), .cmd_x_base(cmd_x_base),
        .cmd_w_base(cmd_w_base), .cmd_y_base(cmd_y_base),
        .lin_start(a_start), .lin_done(lin_done), .lin_x_base(a_x),
        .lin_w_base(a_w), .lin_y_base(a_y), .job_id(a_job), .busy(a_busy),
        .all_done(a_done), .err_timeout(a_err)
    );

    linear_job_sched #(.TIMEOUT_CYC(16)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
        .cmd_job_mask(cmd_job_mask), .cmd_x_base(cmd_x_base),
        .cmd_w_base(cmd_w_base), .cmd_y_base(cmd_y_base),
        .lin_start(b_start), .lin_done(lin_done), .lin_x_base(b_x),
        .lin_w_base(b_w), .lin_y_base(b_y), .job_id(b_job), .busy(b_busy),
        .all_done(b_done), .err_timeout(b_err)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_start = sel ? b_start : a_start;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_err   = sel ? b_err   : a_err;
    assign o_x     = sel ? b_x     : a_x;
    assign o_w     = sel ? b_w     : a_w;
    assign o_y     = sel ? b_y     : a_y;
    assign o_job   = sel ? b_job   : a_job;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (o_start === 1'b1) n_start++;
        if (o_start === 1'b1 && prev_start === 1'b1) n_b2b++;
        prev_start = o_start;
        if (o_done === 1'b1) n_alldone++;
        if (o_err === 1'b1) n_err++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_mask(input logic [3:0] mask, input logic [31:0] x,
                             input logic [31:0] w, input logic [31:0] y);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                e.job = 2'(i);
                e.x   = x;
                e.w   = w + 32'(i) * 32'h1000;
                e.y   = y + 32'(i) * 32'h400;
                sb.push_back(e);
            end
        end
    endtask

    // Drive a command for one cycle; returns in the cycle after the handshake edge.
    task automatic issue(input logic [3:0] mask, input logic [31:0] x,
                         input logic [31:0] w, input logic [31:0] y);
        check("cmd_ready_before_cmd", 32'(o_ready), 32'd1);
        cmd_valid    = 1'b1;
        cmd_job_mask = mask;
        cmd_x_base   = x;
        cmd_w_base   = w;
        cmd_y_base   = y;
        tick();
        cmd_valid = 1'b0;
    endtask

    // A lin_start is required this cycle; compare it against the next queued job.
    task automatic start_check(input string tag);
        exp_t e;
        check({tag, "_start"}, 32'(o_start), 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_queue: observed empty expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_job"}, 32'(o_job), 32'(e.job));
            check({tag, "_x"}, o_x, e.x);
            check({tag, "_w"}, o_w, e.w);
            check({tag, "_y"}, o_y, e.y);
        end
    endtask

    // Engine model: done pulse `delay` cycles after the start cycle; returns at done+1.
    task automatic engine_done(input int delay);
        repeat (delay) tick();
        check("busy_while_running", 32'(o_busy), 32'd1);
        lin_done = 1'b1;
        tick();
        lin_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(o_ready), 32'd1);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_lin_start"}, 32'(o_start), 32'd0);
        check({tag, "_all_done"}, 32'(o_done), 32'd0);
        check({tag, "_err_timeout"}, 32'(o_err), 32'd0);
        check({tag, "_job_id"}, 32'(o_job), 32'd0);
        check({tag, "_x"}, o_x, 32'd0);
        check({tag, "_w"}, o_w, 32'd0);
        check({tag, "_y"}, o_y, 32'd0);
    endtask

    initial begin
        int   s0, d0, e0;
        exp_t e;

        rst          = 1'b1;
        sel          = 1'b0;
        cmd_valid    = 1'b0;
        cmd_job_mask = '0;
        cmd_x_base   = '0;
        cmd_w_base   = '0;
        cmd_y_base   = '0;
        lin_done     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Main batch: jobs 0, 1, 3 with constants taken straight from the plan.
        s0 = n_start; d0 = n_alldone; e0 = n_err;
        e = '{2'd0, 32'h100, 32'h0,    32'h8000}; sb.push_back(e);
        e = '{2'd1, 32'h100, 32'h1000, 32'h8400}; sb.push_back(e);
        e = '{2'd3, 32'h100, 32'h3000, 32'h8C00}; sb.push_back(e);
        issue(4'b1011, 32'h100, 32'h0, 32'h8000);
        start_check("main0");
        engine_done(20);
        start_check("main1");
        engine_done(20);
        start_check("main3");
        engine_done(20);
        check("main_all_done", 32'(o_done), 32'd1);
        check("main_no_start_at_finish", 32'(o_start), 32'd0);
        tick();
        check("main_all_done_one_cycle", 32'(o_done), 32'd0);
        check("main_ready_again", 32'(o_ready), 32'd1);
        check("main_start_count", 32'(n_start - s0), 32'd3);
        check("main_all_done_count", 32'(n_alldone - d0), 32'd1);
        check("main_no_err", 32'(n_err - e0), 32'd0);

        // Zero mask: all_done right after the handshake, ready the cycle after.
        s0 = n_start;
        issue(4'b0000, 32'h1, 32'h2, 32'h3);
        check("zero_all_done", 32'(o_done), 32'd1);
        check("zero_ready_low", 32'(o_ready), 32'd0);
        tick();
        check("zero_ready_high", 32'(o_ready), 32'd1);
        check("zero_all_done_low", 32'(o_done), 32'd0);
        check("zero_no_start", 32'(n_start - s0), 32'd0);

        // cmd_valid held with another mask during a batch is ignored until IDLE.
        push_mask(4'b0101, 32'h200, 32'h10000, 32'h20000);
        issue(4'b0101, 32'h200, 32'h10000, 32'h20000);
        start_check("hold0");
        cmd_valid    = 1'b1;
        cmd_job_mask = 4'b1110;
        cmd_x_base   = 32'h900;
        cmd_w_base   = 32'h70000;
        cmd_y_base   = 32'h60000;
        check("hold_ready_low", 32'(o_ready), 32'd0);
        engine_done(5);
        start_check("hold2");
        engine_done(5);
        check("hold_all_done", 32'(o_done), 32'd1);
        check("hold_ready_finish", 32'(o_ready), 32'd0);
        push_mask(4'b1110, 32'h900, 32'h70000, 32'h60000);
        tick();
        check("hold_ready_idle", 32'(o_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        start_check("second1");
        engine_done(3);
        start_check("second2");
        engine_done(3);
        start_check("second3");
        engine_done(3);
        check("second_all_done", 32'(o_done), 32'd1);
        check("hold_no_b2b", 32'(n_b2b), 32'd0);
        tick();

        // Reset while running job 2: silent abandon, late done ignored.
        s0 = n_start; d0 = n_alldone; e0 = n_err;
        push_mask(4'b0100, 32'h300, 32'h40000, 32'h50000);
        issue(4'b0100, 32'h300, 32'h40000, 32'h50000);
        start_check("rst_job2");
        repeat (3) tick();
        check("rst_busy_before", 32'(o_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        lin_done = 1'b1;
        tick();
        lin_done = 1'b0;
        check("late_done_no_start", 32'(o_start), 32'd0);
        check("late_done_idle", 32'(o_busy), 32'd0);
        tick();
        check("midrst_no_all_done", 32'(n_alldone - d0), 32'd0);
        check("midrst_no_err", 32'(n_err - e0), 32'd0);
        check("midrst_start_count", 32'(n_start - s0), 32'd1);

        // Switch to the TIMEOUT_CYC=16 instance.
        sel = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        s0 = n_start; d0 = n_alldone; e0 = n_err;
        sb.delete();
        e = '{2'd1, 32'h400, 32'h1000, 32'h400}; sb.push_back(e);
        issue(4'b0110, 32'h400, 32'h0, 32'h0);
        start_check("tmo_job1");
        repeat (15) tick();
        check("tmo_not_yet", 32'(o_err), 32'd0);
        check("tmo_busy_before", 32'(o_busy), 32'd1);
        tick();
        check("tmo_err_pulse", 32'(o_err), 32'd1);
        check("tmo_idle", 32'(o_busy), 32'd0);
        check("tmo_job_kept", 32'(o_job), 32'd1);
        tick();
        check("tmo_err_one_cycle", 32'(o_err), 32'd0);
        repeat (20) tick();
        check("tmo_single_start", 32'(n_start - s0), 32'd1);
        check("tmo_no_all_done", 32'(n_alldone - d0), 32'd0);
        check("tmo_err_count", 32'(n_err - e0), 32'd1);

        // lin_done exactly on the terminal count counts as success.
        e0 = n_err;
        push_mask(4'b0011, 32'h500, 32'h100, 32'h200);
        issue(4'b0011, 32'h500, 32'h100, 32'h200);
        start_check("tie0");
        engine_done(15);
        start_check("tie1");
        check("tie_no_err_0", 32'(o_err), 32'd0);
        engine_done(15);
        check("tie_all_done", 32'(o_done), 32'd1);
        check("tie_no_err", 32'(n_err - e0), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
